seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Multiplexed scan controller for a common-anode hex display bank.
- Sits directly upstream of the per-digit 7-segment decoder. Each digit slot drives one 8-bit digit code to the decoder and one active-low digit enable to the display.
- Holds a double-buffered display value with frame-synchronous update (no tearing) and optional leading-zero blanking.
- Inserts an anti-ghosting dead time at the start of every digit slot.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (2..8).
- CLK_DIV, 50000: iCLK cycles per digit slot (>= 2).
- DEAD_CYC, 2: cycles at the start of each slot with all digit enables off (0 <= DEAD_CYC < CLK_DIV).

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iDATA  in  4*NUM_DIGITS  hex value to display; nibble k is digit k, digit 0 = iDATA[3:0].
- iDP  in  NUM_DIGITS  decimal point request per digit, active-high.
- iLOAD  in  1  single-cycle strobe; captures iDATA and iDP into the shadow register.
- iLZ_BLANK  in  1  when 1, leading zeros are blanked.
- oDIG  out  8  digit code to the decoder: {4'h0, nibble}, or 8'hFF to blank.
- oDIG_SEL  out  NUM_DIGITS  digit enables, active-low, at most one low.
- oDP  out  1  decimal point segment, active-low.
- oFRAME  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset is asynchronous on iRST_N low and applies to every register.
  - cnt=0, idx=0; active, shadow and pending cleared.
  - oDIG=8'hFF, oDIG_SEL all ones, oDP=1, oFRAME=0.
- Prescaler:
  - cnt counts 0..CLK_DIV-1. A tick occurs when cnt==CLK_DIV-1; on the tick, cnt returns to 0.
  - On the tick, idx advances by 1. idx wraps from NUM_DIGITS-1 to 0; this is the frame wrap.
- Buffering:
  - iLOAD writes shadow (data and dp) and sets pending.
  - On frame wrap with pending=1, active<=shadow and pending<=0.
  - If iLOAD and frame wrap occur in the same cycle, active<=iDATA/iDP directly, and shadow is also updated; pending ends at 0.
  - Repeated iLOADs within a frame: the last one wins.
- Leading-zero blanking, evaluated on active:
  - With iLZ_BLANK=1, digit k is blanked if k>0 and every nibble at index >= k is 0.
  - Digit 0 is never blanked, so a value of 0 displays "0".
  - A blanked digit drives oDIG=8'hFF and oDP=1, even if its dp bit is set.
- Outputs are registered and lag cnt/idx by exactly one cycle.
  - oDIG = blank ? 8'hFF : {4'h0, active nibble[idx]}.
  - oDP = ~(active dp[idx] & ~blank).
  - oDIG_SEL[idx]=0 only when cnt >= DEAD_CYC; otherwise all ones.
  - oDIG and oDP stay valid during dead time.
- oFRAME is high for exactly the one output cycle following the frame-wrap tick.
- First enable after reset release: oDIG_SEL[0] falls at clock edge DEAD_CYC+1.
- iLZ_BLANK is sampled live each cycle and is not buffered.
- Reset asserted mid-slot: all outputs blank immediately, without waiting for a clock. Scan restarts at digit 0 after release; pending data is lost.

Test Plan (NUM_DIGITS=4, CLK_DIV=4, DEAD_CYC=1):
1. Reset released, no load -> oDIG_SEL=4'b1111 for 1 cycle, then 4'b1110 for 3 cycles. oDIG=8'h00 for digit 0 and 8'hFF for digits 1-3 with iLZ_BLANK=1. Digit enables scan 0,1,2,3 with period 16 cycles; oFRAME pulses every 16 cycles.
2. iLOAD with iDATA=16'h12AF, iLZ_BLANK=0 issued mid-frame -> old value persists until the next oFRAME. Thereafter oDIG sequence per slot is 8'h0F, 8'h0A, 8'h02, 8'h01.
3. iDATA=16'h0030, iLZ_BLANK=1, iDP=4'b1000 -> digits 0,1 show 8'h00, 8'h03. Digits 2,3 show 8'hFF, and oDP stays 1 on digit 3.
4. iLOAD of 16'h1111 coincident with the frame-wrap cycle -> the immediately following frame shows 1111, and pending is clear afterwards.
5. Two iLOADs in one frame (16'hAAAA, then 16'h5555) -> the next frame shows 5555 only; 16'hAAAA is never displayed.
6. iRST_N pulled low while digit 2 is enabled -> oDIG_SEL=4'b1111 and oDIG=8'hFF asynchronously. After release, scanning resumes at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode hex display bank.
// Double-buffered value, frame-synchronous swap, leading-zero blanking, dead time.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 50000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iLOAD,
  input  logic                    iLZ_BLANK,
  output logic [7:0]              oDIG,
  output logic [NUM_DIGITS-1:0]   oDIG_SEL,
  output logic                    oDP,
  output logic                    oFRAME
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] SEL_ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_shd_data;
  logic [NUM_DIGITS-1:0]   r_shd_dp;
  logic                    r_pend;

  logic                  w_tick;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_zhi;
  logic [NUM_DIGITS-1:0] w_blank_vec;
  logic [3:0]            w_nibs [NUM_DIGITS];
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic                  w_dp_bit;
  logic                  w_en;
  logic [7:0]            w_dig_nxt;
  logic [NUM_DIGITS-1:0] w_sel_nxt;
  logic                  w_dp_nxt;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_MAX);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load landing on the wrap cycle bypasses the shadow straight into active.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_shd_data <= '0;
      r_shd_dp   <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (iLOAD) begin
        r_shd_data <= iDATA;
        r_shd_dp   <= iDP;
      end
      if (w_wrap && iLOAD) begin
        r_act_data <= iDATA;
        r_act_dp   <= iDP;
        r_pend     <= 1'b0;
      end else if (w_wrap && r_pend) begin
        r_act_data <= r_shd_data;
        r_act_dp   <= r_shd_dp;
        r_pend     <= 1'b0;
      end else if (iLOAD) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nibs[k] = r_act_data[4*k +: 4];
    end
  end

  // w_zhi[k]: every nibble from k up to the top is zero.
  always_comb begin : zero_scan
    logic w_acc;
    w_acc       = 1'b1;
    w_zhi       = '0;
    w_blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc          = w_acc && (w_nibs[k] == 4'h0);
      w_zhi[k]       = w_acc;
      w_blank_vec[k] = iLZ_BLANK && (k > 0) && w_acc;
    end
  end

  assign w_nib    = w_nibs[r_idx];
  assign w_blank  = w_blank_vec[r_idx];
  assign w_dp_bit = r_act_dp[r_idx];
  assign w_en     = (r_cnt >= DEAD);

  always_comb begin
    w_dig_nxt = w_blank ? 8'hFF : {4'h0, w_nib};
    w_dp_nxt  = ~(w_dp_bit & ~w_blank);
    w_sel_nxt = '1;
    if (w_en) begin
      w_sel_nxt = ~(SEL_ONE << r_idx);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDIG     <= 8'hFF;
      oDIG_SEL <= '1;
      oDP      <= 1'b1;
      oFRAME   <= 1'b0;
    end else begin
      oDIG     <= w_dig_nxt;
      oDIG_SEL <= w_sel_nxt;
      oDP      <= w_dp_nxt;
      oFRAME   <= w_wrap;
    end
  end

endmodule
